// File: rtl/freq_comp_ctrl_pkg.sv
// Shared types and defaults for the oscillator frequency-compensation controller.
// State encoding plus the default widths and the midscale trim code.
package freq_comp_ctrl_pkg;

    localparam int CODE_W_DEF = 10;
    localparam int FREQ_W_DEF = 24;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_S_MEAS     = 4'd1,
        ST_S_WAIT     = 4'd2,
        ST_S_EVAL     = 4'd3,
        ST_V_MEAS     = 4'd4,
        ST_V_WAIT     = 4'd5,
        ST_TRACK_IDLE = 4'd6,
        ST_T_MEAS     = 4'd7,
        ST_T_WAIT     = 4'd8,
        ST_T_EVAL     = 4'd9,
        ST_FAIL       = 4'd10
    } fcc_state_e;

    // Midscale code (only the MSB set) for a trim DAC of width w.
    function automatic logic [31:0] midscale(input int w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/freq_band_cmp.sv
// Unsigned window compare of a measured count against inclusive lower/upper bounds.
module freq_band_cmp
    import freq_comp_ctrl_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF
) (
    input  logic [FREQ_W-1:0] count,
    input  logic [FREQ_W-1:0] lower,
    input  logic [FREQ_W-1:0] upper,
    output logic              too_high,
    output logic              too_low,
    output logic              in_band
);

    assign too_high = count > upper;
    assign too_low  = count < lower;
    assign in_band  = !too_high && !too_low;

endmodule

// File: rtl/freq_comp_ctrl.sv
// Closed-loop trim controller: successive-approximation search of the tune code
// into a per-channel frequency band, then +/-1 drift tracking with re-search on repeated misses.
module freq_comp_ctrl
    import freq_comp_ctrl_pkg::*;
#(
    parameter int CODE_W       = CODE_W_DEF,
    parameter int FREQ_W       = FREQ_W_DEF,
    parameter int TRACK_PERIOD = 4096,
    parameter int MISS_LIMIT   = 4,
    parameter int MEAS_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic [3:0]        channel,
    output logic [3:0]        table_ch,
    input  logic [FREQ_W-1:0] freq_lower,
    input  logic [FREQ_W-1:0] freq_upper,
    output logic              meas_start,
    input  logic              meas_done,
    input  logic [FREQ_W-1:0] meas_count,
    output logic [CODE_W-1:0] tune_code,
    output logic              busy,
    output logic              locked,
    output logic              fail
);

    localparam int BIT_W  = $clog2(CODE_W);
    localparam int TMO_W  = $clog2(MEAS_TIMEOUT + 1);
    localparam int TRK_W  = $clog2(TRACK_PERIOD + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    localparam logic [CODE_W-1:0] MIDSCALE = CODE_W'(midscale(CODE_W));
    localparam logic [BIT_W-1:0]  TOP_BIT  = BIT_W'(CODE_W - 1);

    fcc_state_e          state_q, state_d;
    logic [CODE_W-1:0]   code_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [3:0]          ch_d;
    logic [FREQ_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [TRK_W-1:0]    trk_q, trk_d;
    logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
    logic                busy_d, locked_d, fail_d, mst_d;
    logic                go_track, go_fail;

    logic [FREQ_W-1:0]   cmp_count;
    logic                too_high, too_low, in_band;

    // The verify pass decides straight from the live count; other passes use the captured one.
    assign cmp_count = (state_q == ST_V_WAIT) ? meas_count : cnt_q;
    assign miss_inc  = miss_q + MISS_W'(1);

    freq_band_cmp #(.FREQ_W(FREQ_W)) u_band_cmp (
        .count    (cmp_count),
        .lower    (freq_lower),
        .upper    (freq_upper),
        .too_high (too_high),
        .too_low  (too_low),
        .in_band  (in_band)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = tune_code;
        bit_d    = bit_q;
        ch_d     = table_ch;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        trk_d    = trk_q;
        miss_d   = miss_q;
        busy_d   = busy;
        locked_d = locked;
        fail_d   = fail;
        mst_d    = 1'b0;
        go_track = 1'b0;
        go_fail  = 1'b0;

        if (stop) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FAIL: begin
                    if (start) begin
                        ch_d     = channel;
                        code_d   = MIDSCALE;
                        bit_d    = TOP_BIT;
                        fail_d   = 1'b0;
                        busy_d   = 1'b1;
                        locked_d = 1'b0;
                        state_d  = ST_S_MEAS;
                    end
                end
                ST_S_MEAS: begin
                    mst_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_S_WAIT;
                end
                ST_V_MEAS: begin
                    mst_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_V_WAIT;
                end
                ST_T_MEAS: begin
                    mst_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_T_WAIT;
                end
                ST_S_WAIT, ST_V_WAIT, ST_T_WAIT: begin
                    if (meas_done) begin
                        cnt_d = meas_count;
                        if (state_q == ST_S_WAIT)      state_d = ST_S_EVAL;
                        else if (state_q == ST_T_WAIT) state_d = ST_T_EVAL;
                        else if (in_band)              go_track = 1'b1;
                        else                           go_fail  = 1'b1;
                    end else if (tmo_q == TMO_W'(MEAS_TIMEOUT)) begin
                        go_fail = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ST_S_EVAL: begin
                    if (in_band) begin
                        go_track = 1'b1;
                    end else begin
                        // Too high: drop the trial bit. Too low: keep it.
                        if (too_high) code_d[bit_q] = 1'b0;
                        if (bit_q != '0) begin
                            code_d[bit_q - BIT_W'(1)] = 1'b1;
                            bit_d   = bit_q - BIT_W'(1);
                            state_d = ST_S_MEAS;
                        end else begin
                            state_d = ST_V_MEAS;
                        end
                    end
                end
                ST_TRACK_IDLE: begin
                    if (trk_q == TRK_W'(TRACK_PERIOD - 1)) state_d = ST_T_MEAS;
                    else                                   trk_d   = trk_q + TRK_W'(1);
                end
                ST_T_EVAL: begin
                    if (in_band) begin
                        miss_d  = '0;
                        trk_d   = '0;
                        state_d = ST_TRACK_IDLE;
                    end else if ((too_high && tune_code == '0) || (too_low && tune_code == '1)) begin
                        go_fail = 1'b1;
                    end else if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                        code_d   = MIDSCALE;
                        bit_d    = TOP_BIT;
                        miss_d   = '0;
                        locked_d = 1'b0;
                        busy_d   = 1'b1;
                        state_d  = ST_S_MEAS;
                    end else begin
                        code_d  = too_high ? tune_code - CODE_W'(1) : tune_code + CODE_W'(1);
                        miss_d  = miss_inc;
                        trk_d   = '0;
                        state_d = ST_TRACK_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (go_track) begin
                state_d  = ST_TRACK_IDLE;
                locked_d = 1'b1;
                busy_d   = 1'b0;
                trk_d    = '0;
                miss_d   = '0;
            end
            if (go_fail) begin
                state_d  = ST_FAIL;
                fail_d   = 1'b1;
                busy_d   = 1'b0;
                locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tune_code  <= MIDSCALE;
            bit_q      <= TOP_BIT;
            table_ch   <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            trk_q      <= '0;
            miss_q     <= '0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            meas_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            tune_code  <= code_d;
            bit_q      <= bit_d;
            table_ch   <= ch_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            trk_q      <= trk_d;
            miss_q     <= miss_d;
            busy       <= busy_d;
            locked     <= locked_d;
            fail       <= fail_d;
            meas_start <= mst_d;
        end
    end

endmodule

// File: tb/tb_freq_comp_ctrl.sv
// Scoreboard bench: expected DUT events (measurement requests, lock/unlock, fail) are queued
// by the stimulus and checked by a monitor against an oscillator model f = 7880000 + 160*code.
module tb_freq_comp_ctrl;

    localparam int CODE_W = 10;
    localparam int FREQ_W = 24;
    localparam int TP     = 256;
    localparam int ML     = 4;
    localparam int MT     = 1000;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [3:0]        channel = 4'd0;
    logic [3:0]        table_ch;
    logic [FREQ_W-1:0] freq_lower, freq_upper;
    logic              meas_start;
    logic              meas_done = 1'b0;
    logic [FREQ_W-1:0] meas_count = '0;
    logic [CODE_W-1:0] tune_code;
    logic              busy, locked, fail;

    always #5 clk = ~clk;

    freq_comp_ctrl #(
        .CODE_W(CODE_W), .FREQ_W(FREQ_W), .TRACK_PERIOD(TP),
        .MISS_LIMIT(ML), .MEAS_TIMEOUT(MT)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .channel(channel),
        .table_ch(table_ch), .freq_lower(freq_lower), .freq_upper(freq_upper),
        .meas_start(meas_start), .meas_done(meas_done), .meas_count(meas_count),
        .tune_code(tune_code), .busy(busy), .locked(locked), .fail(fail)
    );

    always_comb begin
        freq_lower = '0;
        freq_upper = '0;
        case (table_ch)
            4'd5: begin freq_lower = 24'd7962296; freq_upper = 24'd7962952; end
            4'd0: begin freq_lower = 24'd7880376; freq_upper = 24'd7881032; end
            default: ;
        endcase
    end

    typedef enum {EV_MEAS, EV_LOCK, EV_UNLOCK, EV_FAIL} ev_kind_e;
    typedef struct {ev_kind_e kind; int code; logic busy;} ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  offset = 0;
    bit  mute = 1'b0;
    int  n_req = 0;
    int  mc;

    int seq_ch5[8] = '{512, 768, 640, 576, 544, 528, 520, 516};
    int seq_ch0[8] = '{512, 256, 128, 64, 32, 16, 8, 4};
    int seq_rel[8] = '{512, 256, 384, 448, 416, 400, 392, 388};

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d..%0d", nm, got, lo, hi);
        end
    endtask

    task automatic push(input ev_kind_e k, input int code, input logic b);
        ev_t e;
        e.kind = k; e.code = code; e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic push_search(input int s[8]);
        for (int i = 0; i < 8; i++) push(EV_MEAS, s[i], 1'b1);
        push(EV_LOCK, s[7], 1'b0);
    endtask

    task automatic ev(input ev_kind_e k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL ev_unexpected got kind=%s code=%0d busy=%0b", k.name(), tune_code, busy);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.code != int'(tune_code) || e.busy !== busy) begin
                failures++;
                $display("FAIL ev_%s got kind=%s code=%0d busy=%0b exp kind=%s code=%0d busy=%0b",
                         e.kind.name(), k.name(), tune_code, busy, e.kind.name(), e.code, e.busy);
            end
        end
    endtask

    function automatic bit cond(input int which, input int arg);
        case (which)
            0:       return locked;
            1:       return fail;
            2:       return !locked;
            default: return n_req >= arg;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int which, input int arg, input int budget,
                            output int n);
        n = 0;
        while (!cond(which, arg) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cond(which, arg)) begin
            failures++;
            $display("FAIL %s wait expired after %0d cycles", nm, budget);
        end
    endtask

    task automatic do_start(input logic [3:0] ch);
        channel = ch;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Oscillator / frequency counter model
    initial forever begin
        @(negedge clk);
        if (resetn && meas_start) begin
            n_req++;
            if (!mute) begin
                mc = int'(tune_code);
                repeat (19) @(negedge clk);
                meas_count = FREQ_W'(7880000 + 160 * mc + offset);
                meas_done = 1'b1;
                @(negedge clk);
                meas_done = 1'b0;
            end
        end
    end

    // Monitor
    logic pl = 1'b0, pf = 1'b0;
    initial forever begin
        @(negedge clk);
        if (resetn) begin
            if (meas_start)        ev(EV_MEAS);
            if (locked && !pl)     ev(EV_LOCK);
            if (!locked && pl)     ev(EV_UNLOCK);
            if (fail && !pf)       ev(EV_FAIL);
        end
        pl = locked;
        pf = fail;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        repeat (3) @(negedge clk);
        chk("rst_tune", int'(tune_code), 512);
        chk("rst_table_ch", int'(table_ch), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_meas_start", int'(meas_start), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Channel 5 search
        push_search(seq_ch5);
        base = n_req;
        do_start(4'd5);
        chk("ch5_busy_after_start", int'(busy), 1);
        wait_for("ch5_lock", 0, 0, 400, n);
        chk("ch5_table_ch", int'(table_ch), 5);
        chk("ch5_busy", int'(busy), 0);
        chk_range("ch5_code", int'(tune_code), 514, 518);
        chk_range("ch5_meas_n", n_req - base, 1, 11);

        // start while locked is ignored
        do_start(4'd3);
        chk("locked_start_ignored_ch", int'(table_ch), 5);
        chk("locked_start_ignored_lk", int'(locked), 1);

        // Drift +800: three downward steps then back in band
        for (int c = 516; c >= 513; c--) push(EV_MEAS, c, 1'b0);
        base = n_req;
        offset = 800;
        wait_for("trk_4meas", 3, base + 4, 4 * (TP + 60), n);
        repeat (30) @(negedge clk);
        chk("trk_code", int'(tune_code), 513);
        chk("trk_locked", int'(locked), 1);

        // Drift +20000: four misses force a re-search
        for (int c = 513; c >= 510; c--) push(EV_MEAS, c, 1'b0);
        push(EV_UNLOCK, 512, 1'b1);
        push_search(seq_rel);
        offset = 20800;
        wait_for("miss_unlock", 2, 0, 5 * (TP + 60), n);
        chk("miss_busy", int'(busy), 1);
        wait_for("relock", 0, 0, 400, n);
        chk("relock_code", int'(tune_code), 388);
        chk("relock_busy", int'(busy), 0);

        push(EV_UNLOCK, 388, 1'b0);
        do_stop();
        chk("stop_trk_locked", int'(locked), 0);
        chk("stop_trk_code", int'(tune_code), 388);

        // Channel 0: search toward the bottom of the code range
        offset = 0;
        push_search(seq_ch0);
        do_start(4'd0);
        wait_for("ch0_lock", 0, 0, 400, n);
        chk("ch0_code", int'(tune_code), 4);
        chk("ch0_table_ch", int'(table_ch), 0);
        push(EV_UNLOCK, 4, 1'b0);
        do_stop();

        // Measurement timeout
        mute = 1'b1;
        push(EV_MEAS, 512, 1'b1);
        push(EV_FAIL, 512, 1'b0);
        do_start(4'd5);
        wait_for("tmo_fail", 1, 0, MT + 50, n);
        chk_range("tmo_latency", n, MT - 2, MT + 6);
        chk("tmo_busy", int'(busy), 0);
        chk("tmo_locked", int'(locked), 0);
        mute = 1'b0;

        // Next start clears fail and searches again
        push_search(seq_ch5);
        do_start(4'd5);
        chk("restart_fail_clr", int'(fail), 0);
        chk("restart_busy", int'(busy), 1);
        wait_for("restart_lock", 0, 0, 400, n);
        chk("restart_code", int'(tune_code), 516);
        push(EV_UNLOCK, 516, 1'b0);
        do_stop();

        // stop during S_WAIT; the late meas_done is ignored
        push(EV_MEAS, 512, 1'b1);
        base = n_req;
        do_start(4'd5);
        wait_for("sw_req", 3, base + 1, 50, n);
        repeat (5) @(negedge clk);
        do_stop();
        chk("stop_wait_busy", int'(busy), 0);
        repeat (30) @(negedge clk);
        chk("stop_wait_busy_late", int'(busy), 0);
        chk("stop_wait_code", int'(tune_code), 512);
        chk("stop_wait_fail", int'(fail), 0);

        // Reset mid-search
        push(EV_MEAS, 512, 1'b1);
        push(EV_MEAS, 768, 1'b1);
        base = n_req;
        do_start(4'd5);
        wait_for("rs_req", 3, base + 2, 100, n);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_tune", int'(tune_code), 512);
        chk("midrst_table_ch", int'(table_ch), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_fail", int'(fail), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
